// File: rtl/coproc_custom0_arbiter.sv
// Round-robin arbiter sharing one custom0 coprocessor stream between
// N_PORTS requesters. The source port of every issued request is kept in
// an in-order ID FIFO so each response is steered back to its issuer.
module coproc_custom0_arbiter #(
    parameter int N_PORTS  = 2,
    parameter int REQ_W    = 64,
    parameter int RESP_W   = 33,
    parameter int ID_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [N_PORTS-1:0]            m_req_i,
    input  logic [N_PORTS*REQ_W-1:0]      m_rdata_bi,
    output logic [N_PORTS-1:0]            m_ack_o,
    output logic [N_PORTS-1:0]            m_resp_req_o,
    output logic [RESP_W-1:0]             m_resp_wdata_bo,
    input  logic [N_PORTS-1:0]            m_resp_ack_i,
    output logic                          cp_req_o,
    output logic [REQ_W-1:0]              cp_wdata_bo,
    input  logic                          cp_ack_i,
    input  logic                          cp_resp_req_i,
    input  logic [RESP_W-1:0]             cp_resp_rdata_bi,
    output logic                          cp_resp_ack_o,
    output logic [$clog2(ID_DEPTH):0]     outstanding_o,
    output logic                          err_o
);

    localparam int IDX_W = $clog2(N_PORTS);
    localparam int PTR_W = $clog2(ID_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(ID_DEPTH);
    localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(N_PORTS - 1);

    // Per-port request words viewed as a packed array (port k at [k*REQ_W +: REQ_W])
    logic [N_PORTS-1:0][REQ_W-1:0] req_words;
    assign req_words = m_rdata_bi;

    // Arbitration state
    logic [IDX_W-1:0] rr_ptr;
    logic             lock_vld;
    logic [IDX_W-1:0] lock_idx;

    // ID FIFO
    logic [ID_DEPTH-1:0][IDX_W-1:0] id_mem;
    logic [PTR_W-1:0]               wr_ptr;
    logic [PTR_W-1:0]               rd_ptr;
    logic [CNT_W-1:0]               count;
    logic                           err;

    logic [IDX_W-1:0] rr_sel;
    logic             rr_hit;
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             issue;
    logic             pop;
    logic             spurious;

    // Round-robin search: first requesting port at or after rr_ptr
    always_comb begin
        rr_sel   = rr_ptr;
        rr_hit   = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= N_PORTS) cand = cand - N_PORTS;
            cand_idx = IDX_W'(cand);
            if (!rr_hit && m_req_i[cand_idx]) begin
                rr_sel = cand_idx;
                rr_hit = 1'b1;
            end
        end
    end

    // Request path: a held lock overrides round-robin; a full FIFO stalls issue.
    // Handshake outputs are forced low while reset is asserted.
    always_comb begin
        grant       = lock_vld ? lock_idx : rr_sel;
        fifo_full   = (count == DEPTH_C);
        cp_req_o    = rst_i & (lock_vld | (|m_req_i)) & ~fifo_full;
        cp_wdata_bo = req_words[grant];
        issue       = cp_req_o & cp_ack_i;
        m_ack_o     = '0;
        m_ack_o[grant] = issue;
    end

    // Response path: steer to FIFO head; with nothing outstanding, sink and flag it
    always_comb begin
        head            = id_mem[rd_ptr];
        fifo_empty      = (count == '0);
        m_resp_req_o    = '0;
        m_resp_wdata_bo = cp_resp_rdata_bi;
        if (fifo_empty) begin
            cp_resp_ack_o = rst_i & cp_resp_req_i;
        end else begin
            m_resp_req_o[head] = rst_i & cp_resp_req_i;
            cp_resp_ack_o      = rst_i & m_resp_ack_i[head];
        end
        pop      = ~fifo_empty & cp_resp_req_i & cp_resp_ack_o;
        spurious = fifo_empty & cp_resp_req_i;
    end

    // Arbitration, lock and ID FIFO state updates
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rr_ptr   <= '0;
            lock_vld <= 1'b0;
            lock_idx <= '0;
            id_mem   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            err      <= 1'b0;
        end else begin
            if (issue) begin
                id_mem[wr_ptr] <= grant;
                wr_ptr         <= wr_ptr + PTR_W'(1);
                rr_ptr         <= (grant == LAST_PORT) ? '0 : grant + IDX_W'(1);
                lock_vld       <= 1'b0;
            end else if (cp_req_o) begin
                lock_vld <= 1'b1;
                lock_idx <= grant;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({issue, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (spurious) err <= 1'b1;
        end
    end

    assign outstanding_o = count;
    assign err_o         = err;

endmodule

// File: tb/tb_coproc_custom0_arbiter.sv
// Scoreboard bench for coproc_custom0_arbiter: expected issuing ports are
// queued as requests are acked and popped as responses are routed back.
module tb_coproc_custom0_arbiter;
    localparam int N = 2, RW = 64, SW = 33, D = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    m_req = '0;
    logic [N*RW-1:0] m_rdata = '0;
    logic [N-1:0]    m_ack;
    logic [N-1:0]    m_resp_req;
    logic [SW-1:0]   m_resp_wdata;
    logic [N-1:0]    m_resp_ack = '0;
    logic            cp_req;
    logic [RW-1:0]   cp_wdata;
    logic            cp_ack = 1'b0;
    logic            cp_resp_req = 1'b0;
    logic [SW-1:0]   cp_resp_rdata = '0;
    logic            cp_resp_ack;
    logic [$clog2(D):0] outstanding;
    logic            err;

    coproc_custom0_arbiter #(.N_PORTS(N), .REQ_W(RW), .RESP_W(SW), .ID_DEPTH(D)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .m_req_i(m_req), .m_rdata_bi(m_rdata), .m_ack_o(m_ack),
        .m_resp_req_o(m_resp_req), .m_resp_wdata_bo(m_resp_wdata), .m_resp_ack_i(m_resp_ack),
        .cp_req_o(cp_req), .cp_wdata_bo(cp_wdata), .cp_ack_i(cp_ack),
        .cp_resp_req_i(cp_resp_req), .cp_resp_rdata_bi(cp_resp_rdata), .cp_resp_ack_o(cp_resp_ack),
        .outstanding_o(outstanding), .err_o(err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int sb_q[$];
    int rr_m = 0;
    int exp_p;

    function automatic logic [RW-1:0] word(input int p, input int n);
        return {32'hC0DE_0000 + 32'(p), 32'(n)};
    endfunction

    task automatic drv_req(input logic [N-1:0] req, input int n);
        m_req   = req;
        m_rdata = {word(1, n), word(0, n)};
    endtask

    task automatic idle();
        m_req = '0; cp_ack = 1'b0; cp_resp_req = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic pop_exp();
        if (sb_q.size() == 0) begin
            exp_p = -1;
            n_vec++; n_err++;
            $display("FAIL sb_underflow: got response with empty scoreboard, want entry");
        end else begin
            exp_p = sb_q.pop_front();
        end
    endtask

    task automatic test_reset();
        m_req = 2'b11; cp_ack = 1'b1; cp_resp_req = 1'b1;
        tick(); tick(); #1;
        n_vec++; if (cp_req !== 1'b0) begin n_err++; $display("FAIL rst_cp_req: got %b want 0", cp_req); end
        n_vec++; if (m_ack !== 2'b00) begin n_err++; $display("FAIL rst_m_ack: got %b want 00", m_ack); end
        n_vec++; if (m_resp_req !== 2'b00) begin n_err++; $display("FAIL rst_resp_req: got %b want 00", m_resp_req); end
        n_vec++; if (cp_resp_ack !== 1'b0) begin n_err++; $display("FAIL rst_resp_ack: got %b want 0", cp_resp_ack); end
        n_vec++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL rst_outstanding: got %0d want 0", outstanding); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", err); end
        idle(); tick(); rst_n = 1'b1; rr_m = 0;
        m_resp_ack = 2'b11;
    endtask

    task automatic test_single();
        drv_req(2'b01, 0); cp_ack = 1'b1;
        mid();
        n_vec++; if (m_ack !== 2'b01) begin n_err++; $display("FAIL single_ack: got %b want 01", m_ack); end
        n_vec++; if (cp_wdata !== word(0, 0)) begin n_err++; $display("FAIL single_wdata: got %h want %h", cp_wdata, word(0, 0)); end
        sb_q.push_back(0); rr_m = 1;
        tick(); idle();
        mid();
        n_vec++; if (outstanding !== 3'd1) begin n_err++; $display("FAIL single_outstanding: got %0d want 1", outstanding); end
        tick(); cp_resp_req = 1'b1; cp_resp_rdata = 33'h1_2345_6789;
        mid(); pop_exp();
        n_vec++; if (m_resp_req !== (2'b01 << exp_p)) begin n_err++; $display("FAIL single_resp_req: got %b want port %0d", m_resp_req, exp_p); end
        n_vec++; if (m_resp_wdata !== 33'h1_2345_6789) begin n_err++; $display("FAIL single_resp_data: got %h want 123456789", m_resp_wdata); end
        n_vec++; if (cp_resp_ack !== 1'b1) begin n_err++; $display("FAIL single_resp_ack: got %b want 1", cp_resp_ack); end
        tick(); cp_resp_req = 1'b0;
        mid();
        n_vec++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL single_drained: got %0d want 0", outstanding); end
        tick();
    endtask

    task automatic test_rr();
        for (int i = 0; i < 4; i++) begin
            drv_req(2'b11, 10 + i); cp_ack = 1'b1;
            mid();
            n_vec++; if (cp_wdata !== word(rr_m, 10 + i)) begin n_err++; $display("FAIL rr_wdata[%0d]: got %h want %h", i, cp_wdata, word(rr_m, 10 + i)); end
            n_vec++; if (m_ack !== (2'b01 << rr_m)) begin n_err++; $display("FAIL rr_ack[%0d]: got %b want port %0d", i, m_ack, rr_m); end
            sb_q.push_back(rr_m); rr_m ^= 1;
            tick();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            cp_resp_req = 1'b1; cp_resp_rdata = 33'(100 + i);
            mid(); pop_exp();
            n_vec++; if (m_resp_req !== (2'b01 << exp_p)) begin n_err++; $display("FAIL rr_resp[%0d]: got %b want port %0d", i, m_resp_req, exp_p); end
            n_vec++; if (m_resp_wdata !== 33'(100 + i)) begin n_err++; $display("FAIL rr_resp_data[%0d]: got %h want %h", i, m_resp_wdata, 33'(100 + i)); end
            tick();
        end
        cp_resp_req = 1'b0;
        mid();
        n_vec++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL rr_drained: got %0d want 0", outstanding); end
        tick();
    endtask

    task automatic test_lock();
        // issue one port-1 request so priority rests on port 0
        drv_req(2'b10, 20); cp_ack = 1'b1;
        mid();
        n_vec++; if (m_ack !== 2'b10) begin n_err++; $display("FAIL lock_pre_ack: got %b want 10", m_ack); end
        sb_q.push_back(1); rr_m = 0;
        tick();
        for (int c = 1; c <= 3; c++) begin
            drv_req((c == 1) ? 2'b10 : 2'b11, 21); cp_ack = 1'b0;
            mid();
            n_vec++; if (cp_wdata !== word(1, 21)) begin n_err++; $display("FAIL lock_hold_wdata[%0d]: got %h want %h", c, cp_wdata, word(1, 21)); end
            n_vec++; if ({cp_req, m_ack} !== 3'b100) begin n_err++; $display("FAIL lock_hold_hs[%0d]: got %b want 100", c, {cp_req, m_ack}); end
            tick();
        end
        cp_ack = 1'b1;
        mid();
        n_vec++; if (m_ack !== 2'b10) begin n_err++; $display("FAIL lock_release_ack: got %b want 10", m_ack); end
        sb_q.push_back(1); rr_m = 0;
        tick();
        drv_req(2'b11, 22);
        mid();
        n_vec++; if (m_ack !== 2'b01) begin n_err++; $display("FAIL lock_next_ack: got %b want 01", m_ack); end
        n_vec++; if (cp_wdata !== word(0, 22)) begin n_err++; $display("FAIL lock_next_wdata: got %h want %h", cp_wdata, word(0, 22)); end
        sb_q.push_back(0); rr_m = 1;
        tick(); idle();
        mid();
        n_vec++; if (outstanding !== 3'd3) begin n_err++; $display("FAIL lock_outstanding: got %0d want 3", outstanding); end
        tick();
        for (int i = 0; i < 3; i++) begin
            cp_resp_req = 1'b1; cp_resp_rdata = 33'(300 + i);
            mid(); pop_exp();
            n_vec++; if (m_resp_req !== (2'b01 << exp_p)) begin n_err++; $display("FAIL lock_resp[%0d]: got %b want port %0d", i, m_resp_req, exp_p); end
            tick();
        end
        cp_resp_req = 1'b0;
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            drv_req(2'b11, 30 + i); cp_ack = 1'b1;
            mid();
            n_vec++; if (m_ack !== (2'b01 << rr_m)) begin n_err++; $display("FAIL full_fill_ack[%0d]: got %b want port %0d", i, m_ack, rr_m); end
            sb_q.push_back(rr_m); rr_m ^= 1;
            tick();
        end
        drv_req(2'b11, 34);
        mid();
        n_vec++; if (outstanding !== 3'd4) begin n_err++; $display("FAIL full_count: got %0d want 4", outstanding); end
        n_vec++; if ({cp_req, m_ack} !== 3'b000) begin n_err++; $display("FAIL full_stall: got %b want 000", {cp_req, m_ack}); end
        tick();
        cp_resp_req = 1'b1; cp_resp_rdata = 33'h0_0000_0200;
        mid(); pop_exp();
        n_vec++; if ({cp_req, m_ack} !== 3'b000) begin n_err++; $display("FAIL full_pop_no_push: got %b want 000", {cp_req, m_ack}); end
        n_vec++; if (m_resp_req !== (2'b01 << exp_p)) begin n_err++; $display("FAIL full_pop_resp: got %b want port %0d", m_resp_req, exp_p); end
        tick(); cp_resp_req = 1'b0;
        mid();
        n_vec++; if (outstanding !== 3'd3) begin n_err++; $display("FAIL full_after_pop: got %0d want 3", outstanding); end
        n_vec++; if (m_ack !== (2'b01 << rr_m)) begin n_err++; $display("FAIL full_resume_ack: got %b want port %0d", m_ack, rr_m); end
        n_vec++; if (cp_wdata !== word(rr_m, 34)) begin n_err++; $display("FAIL full_resume_wdata: got %h want %h", cp_wdata, word(rr_m, 34)); end
        sb_q.push_back(rr_m); rr_m ^= 1;
        tick(); idle();
        for (int i = 0; i < 4; i++) begin
            cp_resp_req = 1'b1; cp_resp_rdata = 33'(400 + i);
            mid(); pop_exp();
            n_vec++; if (m_resp_req !== (2'b01 << exp_p)) begin n_err++; $display("FAIL full_resp[%0d]: got %b want port %0d", i, m_resp_req, exp_p); end
            tick();
        end
        cp_resp_req = 1'b0;
        mid();
        n_vec++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL full_drained: got %0d want 0", outstanding); end
        tick();
    endtask

    task automatic test_spurious();
        m_resp_ack = 2'b00; cp_resp_req = 1'b1; cp_resp_rdata = 33'h1_DEAD_BEEF;
        mid();
        n_vec++; if (cp_resp_ack !== 1'b1) begin n_err++; $display("FAIL spur_ack: got %b want 1", cp_resp_ack); end
        n_vec++; if (m_resp_req !== 2'b00) begin n_err++; $display("FAIL spur_route: got %b want 00", m_resp_req); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL spur_err_early: got %b want 0", err); end
        tick(); cp_resp_req = 1'b0; m_resp_ack = 2'b11;
        mid();
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL spur_err: got %b want 1", err); end
        repeat (10) tick();
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL spur_err_sticky: got %b want 1", err); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            drv_req(2'b11, 40 + i); cp_ack = 1'b1;
            mid();
            n_vec++; if (m_ack !== (2'b01 << rr_m)) begin n_err++; $display("FAIL ar_fill_ack[%0d]: got %b want port %0d", i, m_ack, rr_m); end
            sb_q.push_back(rr_m); rr_m ^= 1;
            tick();
        end
        drv_req(2'b11, 43); cp_ack = 1'b0;
        mid();
        n_vec++; if (cp_wdata !== word(rr_m, 43)) begin n_err++; $display("FAIL ar_lock_wdata: got %h want %h", cp_wdata, word(rr_m, 43)); end
        tick();
        cp_ack = 1'b1; cp_resp_req = 1'b1; cp_resp_rdata = 33'h0_0000_0500;
        #1;
        n_vec++; if (m_ack !== (2'b01 << rr_m)) begin n_err++; $display("FAIL ar_pre_ack: got %b want port %0d", m_ack, rr_m); end
        n_vec++; if (m_resp_req !== (2'b01 << sb_q[0])) begin n_err++; $display("FAIL ar_pre_resp: got %b want port %0d", m_resp_req, sb_q[0]); end
        rst_n = 1'b0;
        #1;
        n_vec++; if ({cp_req, m_ack} !== 3'b000) begin n_err++; $display("FAIL ar_req_ack: got %b want 000", {cp_req, m_ack}); end
        n_vec++; if ({m_resp_req, cp_resp_ack} !== 3'b000) begin n_err++; $display("FAIL ar_resp: got %b want 000", {m_resp_req, cp_resp_ack}); end
        n_vec++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL ar_outstanding: got %0d want 0", outstanding); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL ar_err: got %b want 0", err); end
        sb_q.delete(); rr_m = 0;
        idle(); tick(); tick(); rst_n = 1'b1;
        drv_req(2'b11, 50); cp_ack = 1'b1;
        mid();
        n_vec++; if (m_ack !== 2'b01) begin n_err++; $display("FAIL ar_first_prio: got %b want 01", m_ack); end
        n_vec++; if (cp_wdata !== word(0, 50)) begin n_err++; $display("FAIL ar_first_wdata: got %h want %h", cp_wdata, word(0, 50)); end
        tick(); idle();
        mid();
        n_vec++; if (outstanding !== 3'd1) begin n_err++; $display("FAIL ar_post_count: got %0d want 1", outstanding); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL ar_post_err: got %b want 0", err); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr();
        test_lock();
        test_full();
        test_spurious();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/coproc_custom0_arbiter.md
Name: coproc_custom0_arbiter

Overview:
Shares one custom0 coprocessor stream port (a MUL_DIV-class execution unit behind req/ack genfifo streams) between N_PORTS requesters, e.g. several harts of a sigma tile.
- Round-robin arbitration on the request stream, with grant locking until the coprocessor accepts.
- Records the source port of every issued request in an in-order ID FIFO.
- Routes each coprocessor response back to the port that issued it.
- Coprocessor responses must come back in issue order.

Parameters:
N_PORTS, 2, number of requester ports (2..8)
REQ_W, 64, packed width of one request word (req_struct bits)
RESP_W, 33, packed width of one response word (resp_struct bits)
ID_DEPTH, 4, maximum outstanding requests (power of 2, >=2)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous active-low reset
m_req_i  in  N_PORTS  per-port request valid
m_rdata_bi  in  N_PORTS*REQ_W  per-port request word; port k at bits [k*REQ_W +: REQ_W]
m_ack_o  out  N_PORTS  per-port request accepted this cycle
m_resp_req_o  out  N_PORTS  per-port response valid
m_resp_wdata_bo  out  RESP_W  response word, broadcast to all ports
m_resp_ack_i  in  N_PORTS  per-port response accepted
cp_req_o  out  1  request valid to coprocessor
cp_wdata_bo  out  REQ_W  request word to coprocessor
cp_ack_i  in  1  coprocessor accepted request
cp_resp_req_i  in  1  coprocessor response valid
cp_resp_rdata_bi  in  RESP_W  coprocessor response word
cp_resp_ack_o  out  1  response consumed
outstanding_o  out  $clog2(ID_DEPTH)+1  ID FIFO occupancy
err_o  out  1  sticky: response received with no outstanding request

Behaviour:
- Handshake (genfifo): a transfer occurs in a cycle where req and ack are both 1. Requesters hold req and data stable until acked. Ack may depend combinationally on req.
- State: rr_ptr (next-priority port), lock_vld, lock_idx, ID FIFO (ID_DEPTH x $clog2(N_PORTS), rd/wr pointers, count), err.
- Reset (rst_i=0, async): rr_ptr=0, lock_vld=0, FIFO empty, err=0. While reset is asserted, all req/ack outputs are 0, outstanding_o=0 and err_o=0. The data outputs carry don't-care values.

Grant selection:
- If lock_vld, g=lock_idx.
- Otherwise g is the first k with m_req_i[k]=1, searching rr_ptr, rr_ptr+1, ... mod N_PORTS.
- cp_req_o = (lock_vld | any m_req_i) & (count<ID_DEPTH).
- cp_wdata_bo = slice g of m_rdata_bi.
- m_ack_o[g] = cp_req_o & cp_ack_i. All other m_ack_o bits are 0.

Issue and locking:
- On issue (cp_req_o & cp_ack_i): push g into the FIFO, rr_ptr <= (g+1) mod N_PORTS, lock_vld <= 0.
- If cp_req_o=1 and cp_ack_i=0: lock_vld <= 1, lock_idx <= g. The grant holds regardless of other ports.
- Full FIFO (count==ID_DEPTH): cp_req_o=0, no ack to any port, lock unchanged. A pop in the same cycle does not enable a push; the push waits one cycle.

Response routing:
- h = FIFO head.
- If count>0: m_resp_req_o[h] = cp_resp_req_i, m_resp_wdata_bo = cp_resp_rdata_bi, cp_resp_ack_o = m_resp_ack_i[h]. On cp_resp_req_i & cp_resp_ack_o, pop.
- If count==0 and cp_resp_req_i=1: the response is spurious. cp_resp_ack_o=1, the response is dropped, all m_resp_req_o=0, err <= 1. err clears only on reset.
- Push and pop in the same cycle: count is unchanged and both pointers advance. A response cannot bypass an empty FIFO in the cycle of the push.
- Pointers wrap modulo ID_DEPTH. count has range 0..ID_DEPTH inclusive.
- Latency: zero-cycle combinational paths in both directions. The only added delay is full-FIFO stall.
- Reset mid-operation discards outstanding IDs. The coprocessor and requesters must be reset in the same domain.

Test Plan:
- Port 0 raises req; cp_ack_i=1 -> m_ack_o=01 the same cycle, outstanding_o=1. Response 0x1_2345_6789 returns -> m_resp_req_o=01 with that word; outstanding_o=0.
- Both ports request continuously; cp_ack_i=1 every cycle -> grants alternate 0,1,0,1 on cp_wdata_bo; rr_ptr toggles each cycle.
- Port 1 requests with cp_ack_i=0 for 3 cycles, port 0 raises req in cycle 2 -> cp_wdata_bo stays port 1's word. The 4th-cycle ack goes to port 1, and port 0 is granted next.
- Issue 4 requests while withholding responses -> outstanding_o=4, cp_req_o=0, 5th not acked. One response popped -> the 5th issues one cycle later; responses return to the ports in issue order.
- cp_resp_req_i=1 with FIFO empty -> cp_resp_ack_o=1, m_resp_req_o=00, err_o=1, still 1 after 10 cycles.
- Assert rst_i=0 with 3 outstanding and a held lock -> outputs go to 0 immediately (asynchronously). After release: outstanding_o=0, err_o=0, and port 0 has first priority.
